// File: rtl/mem_responder.sv
// Single-port word memory behind a valid/ready request/response handshake.
// There is at most one request in flight; each one passes through IDLE -> WAIT -> ACCESS -> RESP.
module mem_responder #(
    parameter int DEPTH_WORDS = 4096,
    parameter int WAIT_STATES = 1,
    parameter bit SWAP_BYTES  = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [17:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error
);
    localparam int          IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] DEPTH_U   = DEPTH_WORDS;
    localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_STATES);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    logic [1:0]       state;
    logic [3:0]       wait_cnt;
    logic             write_p0;
    logic [17:0]      addr_p0;
    logic [31:0]      wdata_p0;
    logic [3:0]       be_p0;
    logic             in_range;
    logic             accept;
    logic [IDX_W-1:0] idx;
    logic [31:0]      mem [DEPTH_WORDS];

    function automatic logic [31:0] swap_word(input logic [31:0] w);
        return SWAP_BYTES ? {w[7:0], w[15:8], w[23:16], w[31:24]} : w;
    endfunction

    assign req_ready = (state == S_IDLE);
    assign rsp_valid = (state == S_RESP);
    assign accept    = req_valid && req_ready;
    // Full 18-bit compare so that addresses beyond the array never alias back into it
    assign in_range  = ({14'd0, addr_p0} < DEPTH_U);
    assign idx       = addr_p0[IDX_W-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            wait_cnt  <= 4'd0;
            rsp_rdata <= 32'd0;
            rsp_error <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        wait_cnt <= WAIT_LOAD;
                        state    <= (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
                    end
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt <= 4'd1)
                        state <= S_ACCESS;
                end
                S_ACCESS: begin
                    state     <= S_RESP;
                    rsp_error <= !in_range;
                    rsp_rdata <= (in_range && !write_p0) ? swap_word(mem[idx]) : 32'd0;
                end
                S_RESP: begin
                    if (rsp_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // ---- request capture stage
    always_ff @(posedge clk) begin
        if (accept) begin
            write_p0 <= req_write;
            addr_p0  <= req_addr;
            wdata_p0 <= req_wdata;
            be_p0    <= req_be;
        end
    end

    // ---- memory commit stage; the write is dropped if reset lands on the ACCESS exit edge
    always_ff @(posedge clk) begin
        if (!reset && state == S_ACCESS && write_p0 && in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (be_p0[i])
                    mem[idx][8*i +: 8] <= wdata_p0[8*i +: 8];
            end
        end
    end

endmodule
